// File: rtl/tank_pkg.sv
// Shared definitions for the tank game key front end.
package tank_pkg;

  localparam int KEY_LEFT  = 2;
  localparam int KEY_FIRE  = 1;
  localparam int KEY_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT,
    LOCKED
  } move_state_e;

endpackage

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser plus debounce counter; level_o and a one-cycle rise_o
// are both registered and update on the same edge.
module key_debounce #(
  parameter int DB_COUNT = 500000,
  parameter int CNT_W    = 25
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_i,
  output logic level_o,
  output logic rise_o
);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;

  // The level flips on the edge after the counter has seen DB_COUNT mismatching samples.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], key_i};
      rise_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DB_COUNT)) begin
        level_q <= sync_q[1];
        rise_q  <= sync_q[1];
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/key_conditioner.sv
// Key front end: debounces left/fire/right and turns presses into one-cycle commands.
// Move keys auto-repeat and lock each other out; fire is one-shot and masked by fire_busy.
module key_conditioner
  import tank_pkg::*;
#(
  parameter int KEY_ACTIVE_HIGH = 1,
  parameter int DB_COUNT        = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 25
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [2:0] key_raw,
  input  logic       fire_busy,
  output logic [2:0] key_level,
  output logic [1:0] move_pulse,
  output logic       fire_pulse
);

  logic [2:0] key_pol;
  logic [2:0] lvl;
  logic [2:0] rise;
  logic       fire_q;

  assign key_pol = (KEY_ACTIVE_HIGH != 0) ? key_raw : ~key_raw;

  for (genvar k = 0; k < 3; k++) begin : g_db
    key_debounce #(
      .DB_COUNT(DB_COUNT),
      .CNT_W   (CNT_W)
    ) u_db (
      .clk    (clk),
      .nrst   (nrst),
      .key_i  (key_pol[k]),
      .level_o(lvl[k]),
      .rise_o (rise[k])
    );
  end

  assign key_level = lvl;

  // Lane 1 is left, lane 0 is right; each locks out when the other key is held.
  for (genvar m = 0; m < 2; m++) begin : g_mv
    localparam int OWN   = (m == 1) ? KEY_LEFT  : KEY_RIGHT;
    localparam int OTHER = (m == 1) ? KEY_RIGHT : KEY_LEFT;

    move_state_e      state_q;
    logic [CNT_W-1:0] tmr_q;
    logic             pulse_q;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        state_q <= IDLE;
        tmr_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        tmr_q   <= '0;
        case (state_q)
          IDLE: begin
            if (rise[OWN]) begin
              if (lvl[OTHER]) begin
                state_q <= LOCKED;
              end else begin
                pulse_q <= 1'b1;
                state_q <= DELAY;
              end
            end
          end
          DELAY: begin
            if (!lvl[OWN]) begin
              state_q <= IDLE;
            end else if (lvl[OTHER]) begin
              state_q <= LOCKED;
            end else if (tmr_q == CNT_W'(REPEAT_DELAY - 1)) begin
              pulse_q <= 1'b1;
              state_q <= REPEAT;
            end else begin
              tmr_q <= tmr_q + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!lvl[OWN]) begin
              state_q <= IDLE;
            end else if (lvl[OTHER]) begin
              state_q <= LOCKED;
            end else if (tmr_q == CNT_W'(REPEAT_PERIOD - 1)) begin
              pulse_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q + CNT_W'(1);
            end
          end
          LOCKED: begin
            if (!lvl[OWN]) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign move_pulse[m] = pulse_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) fire_q <= 1'b0;
    else       fire_q <= rise[KEY_FIRE] & ~fire_busy;
  end

  assign fire_pulse = fire_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: stimulus queues expected pulses (cycle, instance, kind); a negedge
// monitor pops and compares every pulse either instance produces.
module tb_key_conditioner;

  logic       clk;
  logic       nrst;
  logic [2:0] raw0, raw1;
  logic       busy;
  logic [2:0] lvl0, lvl1;
  logic [1:0] mp0, mp1;
  logic       fp0, fp1;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    int dut;
    int kind;
  } ev_t;
  ev_t exp_q[$];

  key_conditioner #(
    .KEY_ACTIVE_HIGH(1), .DB_COUNT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)
  ) u_dut0 (
    .clk(clk), .nrst(nrst), .key_raw(raw0), .fire_busy(busy),
    .key_level(lvl0), .move_pulse(mp0), .fire_pulse(fp0)
  );

  key_conditioner #(
    .KEY_ACTIVE_HIGH(0), .DB_COUNT(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)
  ) u_dut1 (
    .clk(clk), .nrst(nrst), .key_raw(raw1), .fire_busy(1'b0),
    .key_level(lvl1), .move_pulse(mp1), .fire_pulse(fp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int d, input int k);
    ev_t e;
    e.cyc = c; e.dut = d; e.kind = k;
    exp_q.push_back(e);
  endtask

  // kind: 0 = left move, 1 = right move, 2 = fire
  task automatic observe(input int d, input int k, input logic v);
    ev_t e;
    if (v) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: dut%0d kind %0d at cycle %0d, none expected", d, k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.dut != d || e.kind != k) begin
          fails++;
          $display("FAIL pulse_match: got dut%0d kind %0d cycle %0d, expected dut%0d kind %0d cycle %0d",
                   d, k, cyc, e.dut, e.kind, e.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    chk("move_excl0", int'(mp0 == 2'b11), 0);
    observe(0, 0, mp0[1]);
    observe(0, 1, mp0[0]);
    observe(0, 2, fp0);
    observe(1, 0, mp1[1]);
    observe(1, 1, mp1[0]);
    observe(1, 2, fp1);
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t0, t1;
    logic [2:0] seen;
    nrst = 1'b0; raw0 = 3'b000; raw1 = 3'b111; busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level0", lvl0, 0);
    chk("rst_move0",  mp0,  0);
    chk("rst_fire0",  fp0,  0);
    chk("rst_level1", lvl1, 0);
    nrst = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_level0", lvl0, 0);
    chk("pol_idle_level1", lvl1, 0);

    // Glitch of 3 cycles on left
    raw0[2] = 1'b1;
    repeat (3) @(negedge clk);
    raw0[2] = 1'b0;
    seen = '0;
    repeat (12) begin
      @(negedge clk);
      seen |= lvl0;
    end
    chk("glitch_level", seen, 0);

    // Left held: initial pulse, delayed repeat, periodic repeats
    t0 = cyc + 1;
    raw0[2] = 1'b1;
    push(t0 + 7, 0, 0);  push(t0 + 17, 0, 0); push(t0 + 22, 0, 0);
    push(t0 + 27, 0, 0); push(t0 + 32, 0, 0); push(t0 + 37, 0, 0);
    wait_until(t0 + 5);
    chk("left_level_pre", lvl0, 3'b000);
    wait_until(t0 + 6);
    chk("left_level_on", lvl0, 3'b100);
    wait_until(t0 + 33);
    raw0[2] = 1'b0;
    wait_until(t0 + 60);
    chk("left_level_off", lvl0, 0);

    // Right held, left pressed at +12: both lock out
    t0 = cyc + 1;
    raw0[0] = 1'b1;
    push(t0 + 7, 0, 1); push(t0 + 17, 0, 1);
    wait_until(t0 + 11);
    raw0[2] = 1'b1;
    wait_until(t0 + 19);
    chk("mx_both_level", lvl0, 3'b101);
    wait_until(t0 + 29);
    raw0[0] = 1'b0;
    wait_until(t0 + 40);
    chk("mx_left_only", lvl0, 3'b100);
    wait_until(t0 + 44);
    raw0[2] = 1'b0;
    wait_until(t0 + 59);
    raw0[2] = 1'b1;
    push(t0 + 67, 0, 0);
    wait_until(t0 + 69);
    raw0[2] = 1'b0;
    wait_until(t0 + 90);
    chk("mx_level_off", lvl0, 0);

    // Fire with busy low
    t0 = cyc + 1;
    raw0[1] = 1'b1;
    push(t0 + 7, 0, 2);
    wait_until(t0 + 20);
    chk("fire_level", lvl0, 3'b010);
    raw0[1] = 1'b0;
    wait_until(t0 + 35);

    // Fire with busy high, busy drops while held: no pulse
    busy = 1'b1;
    t0 = cyc + 1;
    raw0[1] = 1'b1;
    wait_until(t0 + 12);
    busy = 1'b0;
    wait_until(t0 + 25);
    raw0[1] = 1'b0;
    wait_until(t0 + 40);

    // Asynchronous reset while left held, then fresh press after release
    t0 = cyc + 1;
    raw0[2] = 1'b1;
    wait_until(t0 + 6);
    chk("mid_level_on", lvl0, 3'b100);
    #2 nrst = 1'b0;
    #1;
    chk("async_rst_level", lvl0, 0);
    chk("async_rst_move",  mp0,  0);
    chk("async_rst_fire",  fp0,  0);
    @(negedge clk);
    nrst = 1'b1;
    t1 = cyc + 1;
    push(t1 + 7, 0, 0);
    wait_until(t1 + 9);
    raw0[2] = 1'b0;
    wait_until(t1 + 35);

    // Active-low instance: driving left low is a press
    t0 = cyc + 1;
    raw1[2] = 1'b0;
    push(t0 + 7, 1, 0);
    wait_until(t0 + 6);
    chk("pol_level_on", lvl1, 3'b100);
    wait_until(t0 + 9);
    raw1[2] = 1'b1;
    wait_until(t0 + 30);
    chk("pol_level_off", lvl1, 0);

    repeat (5) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      $display("FAIL missing_pulse: dut%0d kind %0d expected at cycle %0d, got none", e.dut, e.kind, e.cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
